// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// ALU (req0) and load (req1) writeback, with a registered write stage and flush/halt handshake.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 5,
  parameter int ZERO_REG_DISCARD = 1,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Req0Valid,
  input  logic [ADDR_WIDTH-1:0] Req0Addr,
  input  logic [DATA_WIDTH-1:0] Req0Data,
  output logic                  Req0Ready,
  input  logic                  Req1Valid,
  input  logic [ADDR_WIDTH-1:0] Req1Addr,
  input  logic [DATA_WIDTH-1:0] Req1Data,
  output logic                  Req1Ready,
  input  logic                  FlushReq,
  output logic                  FlushAck,
  output logic                  WriEn,
  output logic [ADDR_WIDTH-1:0] WriAdd,
  output logic [DATA_WIDTH-1:0] WriData,
  output logic [CNT_WIDTH-1:0]  ConflictCnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t                         state, state_nxt;
  logic                           ptr;
  logic [1:0]                     valid, grant;
  logic [1:0][ADDR_WIDTH-1:0]     addr;
  logic [1:0][DATA_WIDTH-1:0]     data;
  logic                           xfer, sel, discard;

  assign valid = {Req1Valid, Req0Valid};
  assign addr  = {Req1Addr, Req0Addr};
  assign data  = {Req1Data, Req0Data};

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (FlushReq) state_nxt = DRAIN;
      DRAIN:   state_nxt = HALT;
      HALT:    if (!FlushReq) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Grants only in RUN, and never in the cycle a flush request is first seen.
  always_comb begin
    grant = 2'b00;
    if (state == RUN && !FlushReq) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    Req0Ready = grant[0];
    Req1Ready = grant[1];
    FlushAck  = (state == HALT);
  end

  assign xfer    = |grant;
  assign sel     = grant[1];
  assign discard = (ZERO_REG_DISCARD != 0) && (addr[sel] == '0);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      WriEn       <= 1'b0;
      WriAdd      <= '0;
      WriData     <= '0;
      ptr         <= 1'b0;
      ConflictCnt <= '0;
    end else begin
      WriEn <= xfer && !discard;
      if (xfer) begin
        WriAdd  <= addr[sel];
        WriData <= data[sel];
        ptr     <= ~sel;
      end
      if (xfer && (&valid) && !(&ConflictCnt)) ConflictCnt <= ConflictCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model of the arbiter's rules.
module tb_regfile_write_arbiter;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        Req0Valid = 1'b0, Req1Valid = 1'b0, FlushReq = 1'b0;
  logic [4:0]  Req0Addr = '0, Req1Addr = '0;
  logic [31:0] Req0Data = '0, Req1Data = '0;
  logic        Req0Ready, Req1Ready, FlushAck, WriEn;
  logic [4:0]  WriAdd;
  logic [31:0] WriData;
  logic [7:0]  ConflictCnt;

  regfile_write_arbiter dut (
    .Clock(Clock), .ResetN(ResetN),
    .Req0Valid(Req0Valid), .Req0Addr(Req0Addr), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Addr(Req1Addr), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
    .FlushReq(FlushReq), .FlushAck(FlushAck),
    .WriEn(WriEn), .WriAdd(WriAdd), .WriData(WriData), .ConflictCnt(ConflictCnt)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = accepting, 1 = draining, 2 = halted.
  int          m_mode, m_ptr, m_cnt;
  logic        m_en;
  logic [4:0]  m_add;
  logic [31:0] m_data;
  logic        m_took0, m_took1;

  // Which requester the rules grant right now (-1: none).
  function automatic int who_wins();
    if (m_mode != 0 || FlushReq) return -1;
    if (Req0Valid && Req1Valid)  return m_ptr;
    if (Req0Valid)               return 0;
    if (Req1Valid)               return 1;
    return -1;
  endfunction

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      m_mode <= 0; m_ptr <= 0; m_cnt <= 0;
      m_en <= 1'b0; m_add <= '0; m_data <= '0;
      m_took0 <= 1'b0; m_took1 <= 1'b0;
    end else begin
      int w;
      w = who_wins();
      m_took0 <= (w == 0);
      m_took1 <= (w == 1);
      if (w >= 0) begin
        m_add  <= (w == 0) ? Req0Addr : Req1Addr;
        m_data <= (w == 0) ? Req0Data : Req1Data;
        m_en   <= (((w == 0) ? Req0Addr : Req1Addr) != 5'd0);
        m_ptr  <= 1 - w;
        if (Req0Valid && Req1Valid && m_cnt < 255) m_cnt <= m_cnt + 1;
      end else begin
        m_en <= 1'b0;
      end
      if (m_mode == 0 && FlushReq)       m_mode <= 1;
      else if (m_mode == 1)              m_mode <= 2;
      else if (m_mode == 2 && !FlushReq) m_mode <= 0;
    end
  end

  always @(negedge Clock) begin
    if (ResetN) begin
      int w;
      w = who_wins();
      chk("Req0Ready", Req0Ready, (w == 0));
      chk("Req1Ready", Req1Ready, (w == 1));
      chk("WriEn", WriEn, m_en);
      chk("WriAdd", WriAdd, m_add);
      chk("WriData", WriData, m_data);
      chk("FlushAck", FlushAck, (m_mode == 2));
      chk("ConflictCnt", ConflictCnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1;
  endtask

  initial begin
    int exp_add[4];
    exp_add = '{1, 2, 1, 2};

    // Reset state
    #2;
    chk("rst_WriEn", WriEn, 0);
    chk("rst_WriAdd", WriAdd, 0);
    chk("rst_WriData", WriData, 0);
    chk("rst_FlushAck", FlushAck, 0);
    chk("rst_ConflictCnt", ConflictCnt, 0);
    tick(); tick();
    ResetN = 1'b1;

    // Single write from req0
    Req0Valid = 1'b1; Req0Addr = 5'd5; Req0Data = 32'hDEADBEEF;
    @(negedge Clock);
    chk("t1_ready", Req0Ready, 1);
    tick();
    Req0Valid = 1'b0;
    @(negedge Clock);
    chk("t1_en", WriEn, 1);
    chk("t1_add", WriAdd, 5);
    chk("t1_data", WriData, 32'hDEADBEEF);
    tick();
    @(negedge Clock);
    chk("t1_en_low", WriEn, 0);

    // Contention alternates grants
    do_reset();
    Req0Valid = 1'b1; Req0Addr = 5'd1; Req0Data = 32'h11;
    Req1Valid = 1'b1; Req1Addr = 5'd2; Req1Data = 32'h22;
    @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant0", Req0Ready, (i % 2 == 0));
      chk("t2_grant1", Req1Ready, (i % 2 == 1));
      tick();
      if (i == 3) begin Req0Valid = 1'b0; Req1Valid = 1'b0; end
      @(negedge Clock);
      chk("t2_add", WriAdd, exp_add[i]);
      chk("t2_en", WriEn, 1);
    end
    chk("t2_cnt", ConflictCnt, 4);

    // Zero-register write is accepted but discarded, pointer still moves
    tick();
    Req0Valid = 1'b1; Req0Addr = 5'd3;
    tick();
    Req0Valid = 1'b0;
    Req1Valid = 1'b1; Req1Addr = 5'd0; Req1Data = 32'h55;
    @(negedge Clock);
    chk("t3_ready1", Req1Ready, 1);
    tick();
    Req0Valid = 1'b1; Req0Addr = 5'd4; Req1Addr = 5'd6;
    @(negedge Clock);
    chk("t3_en", WriEn, 0);
    chk("t3_ptr_grant0", Req0Ready, 1);
    chk("t3_ptr_grant1", Req1Ready, 0);

    // Flush while both valid
    tick();
    FlushReq = 1'b1;
    @(negedge Clock);
    chk("t4_noready0", Req0Ready, 0);
    chk("t4_noready1", Req1Ready, 0);
    tick();
    @(negedge Clock);
    chk("t4_ack_drain", FlushAck, 0);
    tick();
    @(negedge Clock);
    chk("t4_ack", FlushAck, 1);
    tick();
    FlushReq = 1'b0;
    @(negedge Clock);
    chk("t4_ack_hold", FlushAck, 1);
    chk("t4_halt_noready", Req0Ready | Req1Ready, 0);
    tick();
    @(negedge Clock);
    chk("t4_ack_drop", FlushAck, 0);
    chk("t4_resume", Req0Ready | Req1Ready, 1);

    // Reset between a transfer and its output cycle
    tick();
    Req1Valid = 1'b0;
    Req0Valid = 1'b1; Req0Addr = 5'd7; Req0Data = 32'h77;
    @(negedge Clock);
    #2;
    ResetN = 1'b0;
    #1;
    chk("t5_en", WriEn, 0);
    chk("t5_cnt", ConflictCnt, 0);
    tick();
    ResetN = 1'b1;
    Req0Valid = 1'b0;
    @(negedge Clock);
    chk("t5_lost", WriEn, 0);
    tick();
    Req0Valid = 1'b1; Req1Valid = 1'b1;
    @(negedge Clock);
    chk("t5_ptr0", Req0Ready, 1);

    // Saturation
    for (int i = 0; i < 300; i++) tick();
    @(negedge Clock);
    chk("t6_sat", ConflictCnt, 255);

    // Randomized traffic respecting the hold-until-accepted rule
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (m_took0 || !Req0Valid) begin
        Req0Valid = ($urandom_range(0, 9) < 6);
        Req0Addr  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        Req0Data  = $urandom;
      end
      if (m_took1 || !Req1Valid) begin
        Req1Valid = ($urandom_range(0, 9) < 6);
        Req1Addr  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        Req1Data  = $urandom;
      end
      if ($urandom_range(0, 19) == 0) FlushReq = ~FlushReq;
      if ($urandom_range(0, 299) == 0) ResetN = 1'b0;
      else ResetN = 1'b1;
    end
    ResetN = 1'b1;
    tick();
    @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
